// File: rtl/spi_mem_pkg.sv
// ============================================================================
// spi_mem_pkg : opcodes, FSM state encoding and address-wrap helper
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_mem_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_OPCODE   = 4'd1,
    ST_ADDR     = 4'd2,
    ST_RD_FETCH = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_RD_LOAD  = 4'd5,
    ST_RD_HOLD  = 4'd6,
    ST_WR_DATA  = 4'd7,
    ST_IGNORE   = 4'd8
  } state_e;

  function automatic int unsigned addr_next(input int unsigned addr, input int unsigned depth);
    return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_edge_det.sv
// ============================================================================
// spi_edge_det : registered single-edge detector (rising or falling)
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_edge_det #(
  parameter bit RISING = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_edge
);

  logic prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) prev_q <= 1'b0;
    else          prev_q <= i_sig;
  end

  assign o_edge = RISING ? (i_sig & ~prev_q) : (~i_sig & prev_q);

endmodule

`default_nettype wire

// File: rtl/spi_mem_cmd_ctrl.sv
// ============================================================================
// spi_mem_cmd_ctrl : SPI byte stream to synchronous RAM command controller
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_mem_cmd_ctrl
  import spi_mem_pkg::*;
#(
  parameter int ADDR_BYTES = 2,
  parameter int ADDR_W     = 16,
  parameter int MEM_DEPTH  = 65536
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cs,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_rx_valid,
  input  logic              i_tx_ready,
  input  logic [7:0]        i_mem_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd_en,
  output logic              o_mem_wr_en,
  output logic [7:0]        o_mem_wdata,
  output logic [7:0]        o_tx_byte,
  output logic              o_tx_valid,
  output logic              o_err,
  output logic [3:0]        o_state
);

  localparam int SH_W = 8 * ADDR_BYTES;

  state_e            state_q, state_d;
  logic [SH_W-1:0]   shift_q, shift_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              is_rd_q, is_rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_valid_q, tx_valid_d;
  logic              err_q, err_d;

  logic              w_rx_rise;
  logic              w_tx_fall;
  logic [SH_W-1:0]   w_full;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_addr_inc;
  logic              w_addr_bad;

  spi_edge_det #(.RISING(1'b1)) u_rx_det (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_rx_valid),
    .o_edge  (w_rx_rise)
  );

  spi_edge_det #(.RISING(1'b0)) u_tx_det (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_tx_ready),
    .o_edge  (w_tx_fall)
  );

  // Address bytes are slotted MSB-first into a pre-cleared register.
  assign w_full     = shift_q | (SH_W'(i_rx_byte) << (8 * (ADDR_BYTES - 1 - int'(cnt_q))));
  assign w_addr     = ADDR_W'(w_full);
  assign w_addr_bad = ((w_full >> ADDR_W) != '0) || (32'(w_addr) >= MEM_DEPTH);
  assign w_addr_inc = ADDR_W'(addr_next(32'(addr_q), 32'(MEM_DEPTH)));

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    is_rd_d    = is_rd_q;
    addr_d     = addr_q;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    wdata_d    = wdata_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = tx_valid_q;
    err_d      = err_q;

    if (wr_en_q) addr_d = w_addr_inc;

    if (i_cs) begin
      state_d    = ST_IDLE;
      tx_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_OPCODE;
          err_d   = 1'b0;
        end
        ST_OPCODE: if (w_rx_rise) begin
          shift_d = '0;
          cnt_d   = 2'd0;
          is_rd_d = (i_rx_byte == OP_READ);
          if (i_rx_byte == OP_READ || i_rx_byte == OP_WRITE) begin
            state_d = ST_ADDR;
          end else begin
            state_d = ST_IGNORE;
            err_d   = 1'b1;
          end
        end
        ST_ADDR: if (w_rx_rise) begin
          shift_d = w_full;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'(ADDR_BYTES - 1)) begin
            if (w_addr_bad) begin
              state_d = ST_IGNORE;
              err_d   = 1'b1;
            end else begin
              addr_d = w_addr;
              if (is_rd_q) begin
                state_d = ST_RD_FETCH;
                rd_en_d = 1'b1;
              end else begin
                state_d = ST_WR_DATA;
              end
            end
          end
        end
        ST_RD_FETCH: state_d = ST_RD_WAIT;
        ST_RD_WAIT:  state_d = ST_RD_LOAD;
        ST_RD_LOAD: begin
          tx_byte_d  = i_mem_rdata;
          tx_valid_d = 1'b1;
          state_d    = ST_RD_HOLD;
        end
        ST_RD_HOLD: if (w_tx_fall) begin
          tx_valid_d = 1'b0;
          addr_d     = w_addr_inc;
          rd_en_d    = 1'b1;
          state_d    = ST_RD_FETCH;
        end
        ST_WR_DATA: if (w_rx_rise) begin
          wdata_d = i_rx_byte;
          wr_en_d = 1'b1;
        end
        ST_IGNORE: state_d = ST_IGNORE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= 2'd0;
      is_rd_q    <= 1'b0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wdata_q    <= 8'h00;
      tx_byte_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      is_rd_q    <= is_rd_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      wdata_q    <= wdata_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  assign o_mem_addr  = addr_q;
  assign o_mem_rd_en = rd_en_q;
  assign o_mem_wr_en = wr_en_q;
  assign o_mem_wdata = wdata_q;
  assign o_tx_byte   = tx_byte_q;
  assign o_tx_valid  = tx_valid_q;
  assign o_err       = err_q;
  assign o_state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_mem_cmd_ctrl.sv
// ============================================================================
// tb_spi_mem_cmd_ctrl : directed bench with a 256-byte RAM model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_mem_cmd_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_cs = 1'b1;
  logic [7:0]  i_rx_byte = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        i_tx_ready = 1'b0;
  logic [7:0]  i_mem_rdata = 8'h00;
  logic [15:0] o_mem_addr;
  logic        o_mem_rd_en;
  logic        o_mem_wr_en;
  logic [7:0]  o_mem_wdata;
  logic [7:0]  o_tx_byte;
  logic        o_tx_valid;
  logic        o_err;
  logic [3:0]  o_state;

  int n_checks = 0;
  int n_errors = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int overlap  = 0;
  int snap;
  logic [7:0]  mem [256];
  logic [15:0] rd_log [$];

  spi_mem_cmd_ctrl #(.ADDR_BYTES(2), .ADDR_W(16), .MEM_DEPTH(256)) u_dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_cs        (i_cs),
    .i_rx_byte   (i_rx_byte),
    .i_rx_valid  (i_rx_valid),
    .i_tx_ready  (i_tx_ready),
    .i_mem_rdata (i_mem_rdata),
    .o_mem_addr  (o_mem_addr),
    .o_mem_rd_en (o_mem_rd_en),
    .o_mem_wr_en (o_mem_wr_en),
    .o_mem_wdata (o_mem_wdata),
    .o_tx_byte   (o_tx_byte),
    .o_tx_valid  (o_tx_valid),
    .o_err       (o_err),
    .o_state     (o_state)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous RAM model; read data held until the next read strobe.
  always @(posedge i_clk) begin
    if (o_mem_rd_en && o_mem_wr_en) overlap++;
    if (o_mem_wr_en) begin
      wr_cnt++;
      mem[o_mem_addr[7:0]] <= o_mem_wdata;
    end
    if (o_mem_rd_en) begin
      rd_cnt++;
      rd_log.push_back(o_mem_addr);
      i_mem_rdata <= mem[o_mem_addr[7:0]];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Byte is accepted at the edge inside this task; returns #1 after it.
  task automatic rx_accept(input logic [7:0] b);
    i_rx_byte  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_accept(b);
    tick();
  endtask

  task automatic frame_start(input logic [7:0] op, input logic [15:0] addr);
    i_cs = 1'b0;
    tick();
    send(op);
    send(addr[15:8]);
    send(addr[7:0]);
  endtask

  task automatic frame_end();
    i_cs = 1'b1;
    tick();
  endtask

  task automatic wait_tx(input string tag);
    for (int i = 0; i < 12; i++) begin
      if (o_tx_valid) break;
      tick();
    end
    check_eq(tag, o_tx_valid, 1);
  endtask

  task automatic pull(input string tag, input logic [7:0] exp);
    wait_tx({tag, "_valid"});
    check_eq(tag, o_tx_byte, exp);
    i_tx_ready = 1'b1;
    tick();
    i_tx_ready = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #1;
    check_eq("rst_state", o_state, 0);
    check_eq("rst_outs", {o_mem_addr, o_mem_rd_en, o_mem_wr_en, o_tx_valid, o_err}, 0);
    check_eq("rst_bytes", {o_mem_wdata, o_tx_byte}, 0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // Write 0xA5 0x5A at 0x0010
    i_cs = 1'b0;
    tick();
    check_eq("st_opcode", o_state, 1);
    send(8'h02); send(8'h00); send(8'h10);
    check_eq("st_wr_data", o_state, 7);
    check_eq("wr_addr0", o_mem_addr, 16'h0010);
    rx_accept(8'hA5);
    check_eq("wr_strobe", o_mem_wr_en, 1);
    check_eq("wr_data0", o_mem_wdata, 8'hA5);
    check_eq("wr_addr_hold", o_mem_addr, 16'h0010);
    tick();
    check_eq("wr_strobe_end", o_mem_wr_en, 0);
    check_eq("wr_addr_inc", o_mem_addr, 16'h0011);
    send(8'h5A);
    frame_end();
    check_eq("st_idle", o_state, 0);
    check_eq("ram10", mem[8'h10], 8'hA5);
    check_eq("ram11", mem[8'h11], 8'h5A);
    check_eq("wr_count", wr_cnt, 2);

    // Read back with exact latency
    snap = rd_cnt;
    i_cs = 1'b0;
    tick();
    send(8'h03); send(8'h00);
    rx_accept(8'h10);
    check_eq("rd_k1_strobe", o_mem_rd_en, 1);
    check_eq("rd_k1_state", o_state, 3);
    tick();
    check_eq("rd_k2_strobe", o_mem_rd_en, 0);
    tick();
    check_eq("rd_k3_valid", o_tx_valid, 0);
    tick();
    check_eq("rd_k3p_valid", o_tx_valid, 1);
    check_eq("rd_byte0", o_tx_byte, 8'hA5);
    check_eq("rd_strobes1", rd_cnt - snap, 1);
    send(8'hFF);
    check_eq("rd_dummy_state", o_state, 6);
    check_eq("rd_dummy_nowr", wr_cnt, 2);
    i_tx_ready = 1'b1;
    tick();
    i_tx_ready = 1'b0;
    tick();
    check_eq("m_valid_drop", o_tx_valid, 0);
    check_eq("m_addr_inc", o_mem_addr, 16'h0011);
    check_eq("m_strobe", o_mem_rd_en, 1);
    tick();
    check_eq("m1_strobe", o_mem_rd_en, 0);
    tick();
    check_eq("m2_valid", o_tx_valid, 0);
    tick();
    check_eq("m3_valid", o_tx_valid, 1);
    check_eq("rd_byte1", o_tx_byte, 8'h5A);
    frame_end();

    // Wrap-around at MEM_DEPTH
    frame_start(8'h02, 16'h00FF);
    send(8'h11); send(8'h22); send(8'h33);
    frame_end();
    check_eq("wrap_wr00", mem[8'h00], 8'h22);
    rd_log.delete();
    frame_start(8'h03, 16'h00FF);
    pull("wrap_b0", 8'h11);
    pull("wrap_b1", 8'h22);
    pull("wrap_b2", 8'h33);
    frame_end();
    check_eq("wrap_n", rd_log.size() >= 3, 1);
    check_eq("wrap_a0", rd_log[0], 16'h00FF);
    check_eq("wrap_a1", rd_log[1], 16'h0000);
    check_eq("wrap_a2", rd_log[2], 16'h0001);

    // Bad opcode
    snap = rd_cnt + wr_cnt;
    i_cs = 1'b0;
    tick();
    send(8'h7E);
    check_eq("badop_err", o_err, 1);
    check_eq("badop_state", o_state, 8);
    send(8'h00); send(8'h10); send(8'hAB);
    i_tx_ready = 1'b1; tick(); i_tx_ready = 1'b0; tick();
    check_eq("badop_nostrobe", rd_cnt + wr_cnt, snap);
    frame_end();
    check_eq("badop_sticky", o_err, 1);
    i_cs = 1'b0;
    tick();
    check_eq("err_clear", o_err, 0);
    frame_end();

    // Address out of range
    snap = rd_cnt + wr_cnt;
    frame_start(8'h03, 16'h0100);
    check_eq("badaddr_err", o_err, 1);
    check_eq("badaddr_state", o_state, 8);
    i_tx_ready = 1'b1; tick(); i_tx_ready = 1'b0; tick();
    check_eq("badaddr_nostrobe", rd_cnt + wr_cnt, snap);
    frame_end();

    // Abort while holding a read byte
    frame_start(8'h03, 16'h0010);
    wait_tx("abort_pre");
    snap = rd_cnt;
    i_cs = 1'b1;
    tick();
    check_eq("abort_state", o_state, 0);
    check_eq("abort_valid", o_tx_valid, 0);
    tick(); tick();
    check_eq("abort_no_rd", rd_cnt, snap);

    // cs deassert coinciding with a byte
    frame_start(8'h02, 16'h0030);
    snap = wr_cnt;
    i_cs = 1'b1;
    i_rx_byte = 8'hEE;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
    check_eq("csrx_state", o_state, 0);
    tick(); tick();
    check_eq("csrx_nowr", wr_cnt, snap);
    check_eq("csrx_ram", mem[8'h30], 8'h00);

    // Asynchronous reset mid-burst
    frame_start(8'h02, 16'h0020);
    rx_accept(8'h77);
    check_eq("rst_pre_wr", o_mem_wr_en, 1);
    i_rst_n = 1'b0;
    #1;
    check_eq("arst_state", o_state, 0);
    check_eq("arst_outs", {o_mem_addr, o_mem_rd_en, o_mem_wr_en, o_tx_valid, o_err}, 0);
    check_eq("arst_bytes", {o_mem_wdata, o_tx_byte}, 0);
    i_cs = 1'b1;
    tick();
    i_rst_n = 1'b1;
    tick();
    check_eq("arst_ram", mem[8'h20], 8'h00);
    frame_start(8'h02, 16'h0020);
    send(8'h77);
    frame_end();
    frame_start(8'h03, 16'h0020);
    pull("post_rst_rd", 8'h77);
    frame_end();

    check_eq("strobe_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/spi_mem_cmd_ctrl.md
# spi_mem_cmd_ctrl

Parametrised SPI-to-memory command controller for the iCE40 memory test design. It sits between the SPI slave byte engine and an on-chip synchronous RAM. Each chip-select frame carries an opcode byte, then ADDR_BYTES address bytes MSB-first, then a burst. A read burst streams bytes out with auto-increment; a write burst stores incoming bytes with auto-increment. The address wraps at MEM_DEPTH.

## Interface
- ADDR_BYTES, 2: number of address bytes per command (1..3).
- ADDR_W, 16: RAM address width; must be ≤ 8*ADDR_BYTES.
- MEM_DEPTH, 65536: number of RAM locations; must be ≤ 2**ADDR_W.
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_cs  in  1  SPI chip select, active-low framing: 1 = deselected, giving a synchronous abort to IDLE.
- i_rx_byte  in  8  byte from the SPI slave.
- i_rx_valid  in  1  level from the SPI slave; its rising edge marks a new byte.
- i_tx_ready  in  1  high = slave wants a byte; its falling edge = byte loaded.
- i_mem_rdata  in  8  RAM read data, valid 1 cycle after o_mem_rd_en.
- o_mem_addr  out  ADDR_W  RAM address.
- o_mem_rd_en  out  1  one-cycle read strobe.
- o_mem_wr_en  out  1  one-cycle write strobe.
- o_mem_wdata  out  8  write data.
- o_tx_byte  out  8  byte for the SPI slave.
- o_tx_valid  out  1  o_tx_byte is valid.
- o_err  out  1  sticky per frame: bad opcode or address ≥ MEM_DEPTH.
- o_state  out  4  current state encoding, for the test header.

## Operation
- Opcodes: 0x03 READ, 0x02 WRITE; any other value is an error.
- States and transitions:
  - IDLE → OPCODE when i_cs=0.
  - OPCODE → ADDR on a valid opcode; → IGNORE on an invalid opcode (o_err←1).
  - ADDR collects ADDR_BYTES bytes into a shift register, MSB first, with a byte counter.
  - On the last address byte: if addr ≥ MEM_DEPTH → IGNORE (o_err←1); if READ → RD_FETCH; if WRITE → WR_DATA.
  - RD_FETCH → RD_WAIT → RD_LOAD → RD_HOLD. RD_HOLD → RD_FETCH on a falling edge of i_tx_ready.
  - WR_DATA loops in place: each received byte issues one write.
  - IGNORE stays until i_cs=1.
- Edge detection: registered previous values of i_rx_valid and i_tx_ready.
  - rx_rise = i_rx_valid & ~prev.
  - tx_fall = ~i_tx_ready & prev.
- Address increment: (addr == MEM_DEPTH-1) ? 0 : addr+1. The truncated address is ADDR_W bits; upper received bits beyond ADDR_W must be zero, otherwise error.
- i_cs=1 in any state: next state IDLE, o_tx_valid←0, no strobes issued. o_err clears on entry to OPCODE.
- rx_rise in RD_* states is ignored (dummy MOSI bytes). tx_fall outside RD_HOLD is ignored.
- Reset values: state IDLE, o_mem_addr 0, o_mem_rd_en 0, o_mem_wr_en 0, o_mem_wdata 0, o_tx_byte 0, o_tx_valid 0, o_err 0, edge registers 0.

## Timing
- A byte is accepted at the clock edge where rx_rise is seen.
- Write:
  - o_mem_wr_en=1 for exactly the next cycle, with o_mem_addr/o_mem_wdata stable.
  - The address increments at the edge ending the strobe.
- Read:
  - Last address byte accepted at edge k → o_mem_rd_en high in cycle k+1.
  - Data captured at edge k+3 → o_tx_valid=1 from cycle k+3.
  - tx_fall in RD_HOLD at edge m → o_tx_valid=0 and address incremented at m. The next o_tx_valid occurs at m+3.
- Strobes are single-cycle and never coincide.
- i_cs=1 together with rx_rise in the same cycle: i_cs wins and the byte is dropped.
- Reset asserted mid-burst: all outputs return to reset values immediately, asynchronously.

## Structure
- Package spi_mem_pkg:
  - opcode constants OP_READ, OP_WRITE;
  - state encoding constants (4-bit);
  - the address-increment-with-wrap function.
- Sub-module spi_edge_det: one registered rising/falling edge detector with async active-low reset, instantiated twice (rx_valid, tx_ready).

## Test plan
- Write then read back: WRITE 0x02, addr 0x0010, data 0xA5 0x5A → RAM[0x10]=0xA5, RAM[0x11]=0x5A. Then READ 0x03, addr 0x0010 with two tx_ready cycles → o_tx_byte 0xA5 then 0x5A.
- Wrap-around: MEM_DEPTH=256, READ at 0x00FF with three bytes → addresses 0xFF, 0x00, 0x01 read in order.
- Error cases:
  - opcode 0x7E → o_err=1, no strobes until i_cs=1; o_err clears at the next frame's opcode.
  - address 0x0100 with MEM_DEPTH=256 → same behaviour.
- Abort: i_cs=1 in RD_HOLD with o_tx_valid=1 → next cycle state IDLE, o_tx_valid=0, no extra o_mem_rd_en.
- Read latency: last address byte at edge k → o_mem_rd_en in cycle k+1 only, o_tx_valid at k+3. The same cycle counts are checked after a tx_fall.
- Reset mid-burst: i_rst_n=0 during WR_DATA → all outputs 0 without a clock edge. First frame after release behaves normally.
